// File: rtl/pid_pkg.sv
// Shared types and defaults for the PID speed controller: FSM state encoding,
// default datapath widths and the PWM word layout.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERR   = 3'd1,
    MUL_P = 3'd2,
    MUL_I = 3'd3,
    MUL_D = 3'd4,
    SUM   = 3'd5
  } pid_state_t;

  localparam int PID_ERR_W   = 16;
  localparam int PID_GAIN_W  = 8;
  localparam int PID_FRAC_W  = 4;
  localparam int PID_ACC_W   = PID_GAIN_W + PID_ERR_W + 2;
  localparam int PID_INT_LIM = 4096;

  localparam int PWM_W       = 8;
  localparam int PWM_MAG_MAX = 127;
  localparam int PWM_DIR_BIT = 7;

endpackage

// File: rtl/pid_sat.sv
// Signed saturator: narrows IN_W to OUT_W, clamping either to the full OUT_W
// range (LIM = 0) or to the symmetric window +/-LIM (LIM > 0).
module pid_sat #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16,
  parameter int LIM   = 0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] FULL_HI =
    signed'({{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [IN_W-1:0] FULL_LO = ~FULL_HI;
  localparam logic signed [IN_W-1:0] LIM_V   = IN_W'(LIM);
  localparam logic signed [IN_W-1:0] HI      = (LIM > 0) ? LIM_V : FULL_HI;
  localparam logic signed [IN_W-1:0] LO      = (LIM > 0) ? -LIM_V : FULL_LO;

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > HI) begin
      dout = HI[OUT_W-1:0];
    end else if (din < LO) begin
      dout = LO[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/pid_speed_ctrl.sv
// Discrete PID speed controller with one shared multiplier; emits a sign-magnitude PWM word.
// Build option: define PID_DEADBAND_EN to zero errors with |e| <= DEADBAND.
module pid_speed_ctrl
  import pid_pkg::*;
#(
  parameter int ERR_W    = PID_ERR_W,
  parameter int GAIN_W   = PID_GAIN_W,
  parameter int FRAC_W   = PID_FRAC_W,
  parameter int ACC_W    = PID_ACC_W,
  parameter int INT_LIM  = PID_INT_LIM,
  parameter int DEADBAND = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    sample_tick,
  input  logic signed [ERR_W-1:0] setpoint,
  input  logic signed [ERR_W-1:0] feedback,
  input  logic [GAIN_W-1:0]       kp,
  input  logic [GAIN_W-1:0]       ki,
  input  logic [GAIN_W-1:0]       kd,
  output logic [PWM_W-1:0]        pwm_val,
  output logic                    busy,
  output logic                    out_valid
);

  localparam int PROD_W = GAIN_W + 1 + ERR_W;
  localparam int U_W    = ACC_W - FRAC_W;

  pid_state_t state;

  logic signed [ERR_W-1:0] integ;
  logic signed [ERR_W-1:0] e_prev;
  logic signed [ERR_W-1:0] e_p1;
  logic signed [ERR_W-1:0] d_p1;
  logic signed [ACC_W-1:0] acc_p2;

  // ERR stage: error, integrator update and derivative, all saturated
  logic signed [ERR_W:0]   err_raw;
  logic signed [ERR_W-1:0] err_sat;
  logic signed [ERR_W-1:0] err_use;
  logic signed [ERR_W:0]   integ_sum;
  logic signed [ERR_W-1:0] integ_nxt;
  logic signed [ERR_W:0]   diff_raw;
  logic signed [ERR_W-1:0] d_nxt;

  assign err_raw = {setpoint[ERR_W-1], setpoint} - {feedback[ERR_W-1], feedback};

  pid_sat #(.IN_W(ERR_W+1), .OUT_W(ERR_W), .LIM(0)) u_sat_err (
    .din  (err_raw),
    .dout (err_sat)
  );

`ifdef PID_DEADBAND_EN
  localparam logic signed [ERR_W:0] DB_V = (ERR_W+1)'(DEADBAND);
  logic signed [ERR_W:0] err_ext;
  logic signed [ERR_W:0] err_mag;

  assign err_ext = {err_sat[ERR_W-1], err_sat};
  assign err_mag = err_sat[ERR_W-1] ? -err_ext : err_ext;
  assign err_use = (err_mag <= DB_V) ? '0 : err_sat;
`else
  assign err_use = err_sat;
`endif

  assign integ_sum = {integ[ERR_W-1], integ} + {err_use[ERR_W-1], err_use};
  assign diff_raw  = {err_use[ERR_W-1], err_use} - {e_prev[ERR_W-1], e_prev};

  pid_sat #(.IN_W(ERR_W+1), .OUT_W(ERR_W), .LIM(INT_LIM)) u_sat_integ (
    .din  (integ_sum),
    .dout (integ_nxt)
  );

  pid_sat #(.IN_W(ERR_W+1), .OUT_W(ERR_W), .LIM(0)) u_sat_d (
    .din  (diff_raw),
    .dout (d_nxt)
  );

  // MUL stages: one multiplier, operand and gain selected by state
  logic [GAIN_W-1:0]        gain_mux;
  logic signed [ERR_W-1:0]  op_mux;
  logic signed [PROD_W-1:0] gain_x;
  logic signed [PROD_W-1:0] op_x;
  logic signed [PROD_W-1:0] prod;

  always_comb begin
    gain_mux = '0;
    op_mux   = '0;
    case (state)
      MUL_P: begin
        gain_mux = kp;
        op_mux   = e_p1;
      end
      MUL_I: begin
        gain_mux = ki;
        op_mux   = integ;
      end
      MUL_D: begin
        gain_mux = kd;
        op_mux   = d_p1;
      end
      default: ;
    endcase
  end

  assign gain_x = signed'(PROD_W'({1'b0, gain_mux}));
  assign op_x   = PROD_W'(op_mux);
  assign prod   = gain_x * op_x;

  // SUM stage: drop gain fraction, take magnitude without overflow, clamp to 127
  logic signed [U_W-1:0]   u_s;
  logic signed [U_W:0]     u_ext;
  logic signed [U_W:0]     u_abs;
  logic signed [PWM_W-1:0] mag_sat;
  logic                    u_neg;

  assign u_s   = U_W'(acc_p2 >>> FRAC_W);
  assign u_neg = u_s[U_W-1];
  assign u_ext = {u_neg, u_s};
  assign u_abs = u_neg ? -u_ext : u_ext;

  pid_sat #(.IN_W(U_W+1), .OUT_W(PWM_W), .LIM(PWM_MAG_MAX)) u_sat_mag (
    .din  (u_abs),
    .dout (mag_sat)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      state     <= IDLE;
      pwm_val   <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      integ     <= '0;
      e_prev    <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= ERR;
            busy  <= 1'b1;
          end
        end
        ERR: begin
          integ  <= integ_nxt;
          e_prev <= err_use;
          state  <= MUL_P;
        end
        MUL_P: state <= MUL_I;
        MUL_I: state <= MUL_D;
        MUL_D: state <= SUM;
        SUM: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
          // a zero magnitude must never carry the direction bit
          if (mag_sat == '0) begin
            pwm_val <= '0;
          end else begin
            pwm_val <= {u_neg, mag_sat[PWM_DIR_BIT-1:0]};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      ERR: begin
        e_p1   <= err_use;
        d_p1   <= d_nxt;
        acc_p2 <= '0;
      end
      MUL_P, MUL_I, MUL_D: acc_p2 <= acc_p2 + ACC_W'(prod);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pid_speed_ctrl.sv
// Directed bench for pid_speed_ctrl: hand-computed PWM words for P, I, D paths,
// saturation, busy-tick rejection, mid-update disable and reset.
module tb_pid_speed_ctrl;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               sample_tick;
  logic signed [15:0] setpoint;
  logic signed [15:0] feedback;
  logic [7:0]         kp;
  logic [7:0]         ki;
  logic [7:0]         kd;
  logic [7:0]         pwm_val;
  logic               busy;
  logic               out_valid;

  int checks = 0;
  int errors = 0;

  pid_speed_ctrl #(
    .ERR_W   (16),
    .GAIN_W  (8),
    .FRAC_W  (4),
    .ACC_W   (26),
    .INT_LIM (100),
    .DEADBAND(5)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .sample_tick(sample_tick),
    .setpoint   (setpoint),
    .feedback   (feedback),
    .kp         (kp),
    .ki         (ki),
    .kd         (kd),
    .pwm_val    (pwm_val),
    .busy       (busy),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_gains(input logic [7:0] p, input logic [7:0] i, input logic [7:0] d);
    kp = p;
    ki = i;
    kd = d;
  endtask

  task automatic clear_state();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  // Tick in cycle N; result and out_valid expected in cycle N+6.
  task automatic run_update(input logic signed [15:0] sp, input logic signed [15:0] fb,
                            input logic [7:0] exp, input string tag);
    setpoint    = sp;
    feedback    = fb;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_early_vld"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_pwm"}, 32'(pwm_val), 32'(exp));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_vld_pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int         nvalid;
    logic [7:0] last_pwm;

    reset_n     = 1'b0;
    enable      = 1'b1;
    sample_tick = 1'b0;
    setpoint    = '0;
    feedback    = '0;
    set_gains(8'd0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm_val), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // proportional path, sign and saturation
    set_gains(8'd16, 8'd0, 8'd0);
    run_update(16'sd50, 16'sd0, 8'h32, "p_pos");
    run_update(16'sd0, 16'sd50, 8'hB2, "p_neg");
    run_update(16'sd1000, 16'sd0, 8'h7F, "p_sat");

    // fractional gain: +1/16 truncates to 0, -1/16 floors to -1
    set_gains(8'd1, 8'd0, 8'd0);
    run_update(16'sd1, 16'sd0, 8'h00, "u_zero");
    run_update(16'sd0, 16'sd1, 8'h81, "u_neg1");

    // error saturation at both rails with the largest gain
    set_gains(8'd255, 8'd0, 8'd0);
    run_update(16'sd32767, -16'sd32768, 8'h7F, "e_max");
    run_update(-16'sd32768, 16'sd32767, 8'hFF, "e_min");

    // integrator with anti-windup clamp at 100
    set_gains(8'd0, 8'd16, 8'd0);
    clear_state();
    for (int i = 1; i <= 12; i++) begin
      run_update(16'sd10, 16'sd0, 8'((10 * i > 100) ? 100 : 10 * i), $sformatf("i_%0d", i));
    end

    // derivative
    set_gains(8'd0, 8'd0, 8'd16);
    clear_state();
    run_update(16'sd0, 16'sd0, 8'h00, "d_0");
    run_update(16'sd20, 16'sd0, 8'h14, "d_step");
    run_update(16'sd20, 16'sd0, 8'h00, "d_hold");

    // tick while busy is ignored and does not touch the integrator
    set_gains(8'd0, 8'd16, 8'd0);
    clear_state();
    setpoint    = 16'sd10;
    feedback    = 16'sd0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    nvalid   = 0;
    last_pwm = 8'h00;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) begin
        nvalid++;
        last_pwm = pwm_val;
      end
    end
    chk("retick_count", 32'(nvalid), 32'd1);
    chk("retick_pwm", 32'(last_pwm), 32'h0A);
    run_update(16'sd10, 16'sd0, 8'h14, "retick_next");

    // enable dropped during MUL_I
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    chk("dis_pwm", 32'(pwm_val), 32'h00);
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_vld", 32'(out_valid), 32'd0);
    nvalid = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("dis_no_vld", 32'(nvalid), 32'd0);
    run_update(16'sd10, 16'sd0, 8'h0A, "dis_integ_clr");

    // reset asserted during MUL_D
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst_pwm", 32'(pwm_val), 32'h00);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_vld", 32'(out_valid), 32'd0);
    reset_n = 1'b1;
    nvalid  = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("mrst_no_vld", 32'(nvalid), 32'd0);
    run_update(16'sd10, 16'sd0, 8'h0A, "mrst_integ_clr");

    // deadband (DEADBAND = 5 only matters when the option is built in)
    set_gains(8'd16, 8'd0, 8'd0);
    clear_state();
`ifdef PID_DEADBAND_EN
    run_update(16'sd4, 16'sd0, 8'h00, "db_in_pos");
    run_update(16'sd0, 16'sd5, 8'h00, "db_edge_neg");
    run_update(16'sd6, 16'sd0, 8'h06, "db_out");
`else
    run_update(16'sd4, 16'sd0, 8'h04, "db_off_pos");
    run_update(16'sd0, 16'sd5, 8'h85, "db_off_neg");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
